// File: rtl/processing_element.sv
// -----------------------------------------------------------------------------
// processing_element
//
// Computes one element of a matrix product, C[r][c] = sum_k A[r][k]*B[k][c],
// by fetching operands over a shared, arbitrated single-port memory bus.
// A controller hands the PE a (row, column) pair together with a config word.
// The PE acknowledges, requests the bus, then runs two-cycle reads of A and B
// with a multiply-accumulate after each pair. It writes the 32-bit wrapped
// sum to C and raises o_Result_Ready until the next job arrives.
//
// Ports
//   i_Clock            sole clock
//   i_Reset_n          asynchronous active-low reset
//   i_Config           lambda [7:0], gamma [15:8], mu [23:16]
//   i_Index_Valid      this PE's bit of the controller's index-ready vector
//   i_Row_Index        row index r
//   i_Column_Index     column index c
//   o_Indexes_Received one-cycle acknowledge of a new job
//   o_Grant_Request    memory bus request, held until o_Result_Ready rises
//   i_Grant            bus granted
//   o_Memory_Address   word address, holds its last value when unused
//   io_Memory_Data     bidirectional data bus, driven only during a granted write
//   o_Write_Enable     memory write strobe
//   o_Result_Ready     job finished (level)
// -----------------------------------------------------------------------------
module processing_element #(
  parameter int index_width     = 8,
  parameter int greek_size      = 8,
  parameter int memory_size_log = 10,
  parameter int A_BASE          = 2,
  parameter int B_BASE          = 256,
  parameter int C_BASE          = 512
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset_n,
  input  logic [31:0]                i_Config,
  input  logic                       i_Index_Valid,
  input  logic [index_width-1:0]     i_Row_Index,
  input  logic [index_width-1:0]     i_Column_Index,
  output logic                       o_Indexes_Received,
  output logic                       o_Grant_Request,
  input  logic                       i_Grant,
  output logic [memory_size_log-1:0] o_Memory_Address,
  inout  wire  [31:0]                io_Memory_Data,
  output logic                       o_Write_Enable,
  output logic                       o_Result_Ready
);

  typedef logic [memory_size_log-1:0] addr_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACK   = 3'd1,
    S_REQ   = 3'd2,
    S_RD_A  = 3'd3,
    S_RD_B  = 3'd4,
    S_MAC   = 3'd5,
    S_WRITE = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  // base + major*stride + minor, truncated to the memory address width
  function automatic addr_t mem_addr(input logic [31:0] base,
                                     input logic [31:0] major,
                                     input logic [31:0] stride,
                                     input logic [31:0] minor);
    return addr_t'(base + (major * stride) + minor);
  endfunction

  state_t                 state_q, state_d;
  logic [index_width-1:0] row_q, row_d;
  logic [index_width-1:0] col_q, col_d;
  logic [greek_size-1:0]  lambda_q, lambda_d;
  logic [greek_size-1:0]  gamma_q, gamma_d;
  logic [greek_size-1:0]  mu_q, mu_d;
  logic [greek_size-1:0]  k_q, k_d;
  logic [31:0]            acc_q, acc_d;
  logic [31:0]            a_q, a_d;
  logic [31:0]            b_q, b_d;
  logic                   rd_cnt_q, rd_cnt_d;
  addr_t                  addr_q, addr_d;
  logic                   ack_q;
  logic                   greq_q;
  logic                   we_q;
  logic                   rr_q;

  logic [greek_size-1:0]  k_inc_s;
  logic                   wr_drive_s;
  logic                   unused_cfg_s;

  assign k_inc_s      = k_q + {{(greek_size-1){1'b0}}, 1'b1};
  assign unused_cfg_s = ^i_Config[31:24];

  // The write strobe and bus drive drop the moment the grant is withdrawn,
  // so a revoked WRITE never touches memory or fights the new bus owner.
  assign wr_drive_s         = we_q & i_Grant;
  assign o_Write_Enable     = wr_drive_s;
  assign io_Memory_Data     = wr_drive_s ? acc_q : {32{1'bz}};
  assign o_Indexes_Received = ack_q;
  assign o_Grant_Request    = greq_q;
  assign o_Result_Ready     = rr_q;
  assign o_Memory_Address   = addr_q;

  // Next-state, datapath and address computation for the job sequencer
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    lambda_d = lambda_q;
    gamma_d  = gamma_q;
    mu_d     = mu_q;
    k_d      = k_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    rd_cnt_d = rd_cnt_q;
    addr_d   = addr_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_Index_Valid) begin
          row_d    = i_Row_Index;
          col_d    = i_Column_Index;
          lambda_d = i_Config[greek_size-1:0];
          gamma_d  = i_Config[8 +: greek_size];
          mu_d     = i_Config[16 +: greek_size];
          acc_d    = 32'd0;
          k_d      = {greek_size{1'b0}};
          state_d  = S_ACK;
        end else begin
          state_d  = state_q;
        end
      end

      S_ACK: begin
        // Out-of-range index: finish without ever requesting the bus
        if ((32'(row_q) >= 32'(gamma_q)) || (32'(col_q) >= 32'(lambda_q))) begin
          state_d = S_DONE;
        end else begin
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        if (i_Grant) begin
          if (mu_q == {greek_size{1'b0}}) begin
            state_d = S_WRITE;
            addr_d  = mem_addr(32'(C_BASE), 32'(row_q), 32'(lambda_q), 32'(col_q));
          end else begin
            state_d  = S_RD_A;
            rd_cnt_d = 1'b0;
            addr_d   = mem_addr(32'(A_BASE), 32'(row_q), 32'(mu_q), 32'(k_q));
          end
        end else begin
          state_d = S_REQ;
        end
      end

      // Two-cycle read; losing the grant restarts the access from cycle one
      S_RD_A: begin
        if (!i_Grant) begin
          rd_cnt_d = 1'b0;
        end else if (rd_cnt_q == 1'b0) begin
          rd_cnt_d = 1'b1;
        end else begin
          a_d      = io_Memory_Data;
          rd_cnt_d = 1'b0;
          state_d  = S_RD_B;
          addr_d   = mem_addr(32'(B_BASE), 32'(k_q), 32'(lambda_q), 32'(col_q));
        end
      end

      S_RD_B: begin
        if (!i_Grant) begin
          rd_cnt_d = 1'b0;
        end else if (rd_cnt_q == 1'b0) begin
          rd_cnt_d = 1'b1;
        end else begin
          b_d      = io_Memory_Data;
          rd_cnt_d = 1'b0;
          state_d  = S_MAC;
        end
      end

      S_MAC: begin
        acc_d = acc_q + (a_q * b_q);
        k_d   = k_inc_s;
        if ((32'(k_q) + 32'd1) < 32'(mu_q)) begin
          state_d = S_RD_A;
          addr_d  = mem_addr(32'(A_BASE), 32'(row_q), 32'(mu_q), 32'(k_inc_s));
        end else begin
          state_d = S_WRITE;
          addr_d  = mem_addr(32'(C_BASE), 32'(row_q), 32'(lambda_q), 32'(col_q));
        end
      end

      S_WRITE: begin
        if (i_Grant) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WRITE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath registers and outputs registered from the next state
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q  <= S_IDLE;
      row_q    <= {index_width{1'b0}};
      col_q    <= {index_width{1'b0}};
      lambda_q <= {greek_size{1'b0}};
      gamma_q  <= {greek_size{1'b0}};
      mu_q     <= {greek_size{1'b0}};
      k_q      <= {greek_size{1'b0}};
      acc_q    <= 32'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      rd_cnt_q <= 1'b0;
      addr_q   <= {memory_size_log{1'b0}};
      ack_q    <= 1'b0;
      greq_q   <= 1'b0;
      we_q     <= 1'b0;
      rr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      lambda_q <= lambda_d;
      gamma_q  <= gamma_d;
      mu_q     <= mu_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rd_cnt_q <= rd_cnt_d;
      addr_q   <= addr_d;
      ack_q    <= (state_d == S_ACK);
      greq_q   <= (state_d inside {S_REQ, S_RD_A, S_RD_B, S_MAC, S_WRITE});
      we_q     <= (state_d == S_WRITE);
      rr_q     <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_processing_element.sv
// -----------------------------------------------------------------------------
// Bench for processing_element: a behavioural word memory answers reads,
// expected writes are queued when a job starts and popped as the DUT writes.
// -----------------------------------------------------------------------------
module tb_processing_element;

  localparam logic [31:0] CFG_S1 = 32'h0002_0202; // mu=2 gamma=2 lambda=2

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cfg;
  logic        valid;
  logic [7:0]  row;
  logic [7:0]  col;
  logic        grant;
  logic        ack;
  logic        greq;
  logic        we;
  logic        rr;
  logic [9:0]  addr;
  wire  [31:0] bus;

  int errors  = 0;
  int checks  = 0;
  int ack_cnt = 0;
  int gr_cnt  = 0;

  logic [31:0] mem [0:1023];

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  // Memory answers whenever the PE holds a granted bus and is not writing
  assign bus = (greq && grant && !we) ? mem[addr] : 32'hzzzz_zzzz;

  processing_element dut (
    .i_Clock            (clk),
    .i_Reset_n          (rst_n),
    .i_Config           (cfg),
    .i_Index_Valid      (valid),
    .i_Row_Index        (row),
    .i_Column_Index     (col),
    .o_Indexes_Received (ack),
    .o_Grant_Request    (greq),
    .i_Grant            (grant),
    .o_Memory_Address   (addr),
    .io_Memory_Data     (bus),
    .o_Write_Enable     (we),
    .o_Result_Ready     (rr)
  );

  // Count acknowledge and request cycles
  always @(negedge clk) begin
    if (ack) ack_cnt++;
    if (greq) gr_cnt++;
  end

  // Scoreboard: every write must match the next queued expectation
  always @(negedge clk) begin
    if (we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=0x%08h, required no write", addr, bus);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (addr !== e.a || bus !== e.d) begin
          errors++;
          $display("FAIL write: addr=%0d data=0x%08h, required addr=%0d data=0x%08h",
                   addr, bus, e.a, e.d);
        end
      end
      mem[addr] = bus;
    end
  end

  // No write strobe may appear while the grant is withdrawn
  always @(negedge clk) begin
    if (!grant) begin
      checks++;
      if (we !== 1'b0) begin
        errors++;
        $display("FAIL we_without_grant: we=%b, required 0", we);
      end
    end
  end

  task automatic load_s1();
    mem[2]   = 32'd1; mem[3]   = 32'd2; mem[4]   = 32'd3; mem[5]   = 32'd4;
    mem[256] = 32'd5; mem[257] = 32'd6; mem[258] = 32'd7; mem[259] = 32'd8;
  endtask

  task automatic push_exp(input logic [9:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // One-cycle i_Index_Valid pulse; returns just after the sampling edge
  task automatic start_job(input logic [7:0] r, input logic [7:0] c, input logic [31:0] cf);
    row   = r;
    col   = c;
    cfg   = cf;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  // Counts edges from the valid-sampling edge until o_Result_Ready; optional
  // stray valid pulses and a grant drop over cycles [drop_at, drop_at+drop_len)
  task automatic wait_done(input bit pulse, input int drop_at, input int drop_len,
                           output int cyc);
    cyc = 0;
    while (rr !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      grant = !(drop_len > 0 && cyc >= drop_at && cyc < drop_at + drop_len);
      valid = pulse && (cyc >= 1) && (cyc <= 5) && (cyc % 2 == 1);
    end
    valid = 1'b0;
    grant = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b0; grant = 1'b1; cfg = 32'd0; row = 8'd0; col = 8'd0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ack, greq, we, rr} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: ack/greq/we/rr=%b, required 0000", {ack, greq, we, rr});
    end
    checks++;
    if (addr !== 10'd0) begin
      errors++;
      $display("FAIL reset_addr: addr=%0d, required 0", addr);
    end
    checks++;
    if (bus !== 32'hzzzz_zzzz && bus !== 32'd0) begin
      errors++;
      $display("FAIL reset_bus: bus=0x%08h, required released", bus);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_job();
    int cyc, a0, g0;
    load_s1();
    push_exp(10'd514, 32'd43);        // 3*5 + 4*7
    a0 = ack_cnt; g0 = gr_cnt;
    start_job(8'd1, 8'd0, CFG_S1);
    wait_done(1'b0, 0, 0, cyc);
    checks++;
    if (cyc != 13) begin
      errors++;
      $display("FAIL basic_latency: cycles=%0d, required 13", cyc);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_write_missing: pending=%0d, required 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (ack_cnt - a0 != 1) begin
      errors++;
      $display("FAIL basic_ack_count: acks=%0d, required 1", ack_cnt - a0);
    end
    checks++;
    if (gr_cnt - g0 != 12) begin
      errors++;
      $display("FAIL basic_req_cycles: cycles=%0d, required 12", gr_cnt - g0);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rr !== 1'b1 || greq !== 1'b0) begin
      errors++;
      $display("FAIL done_hold: rr=%b greq=%b, required rr=1 greq=0", rr, greq);
    end
    checks++;
    if (addr !== 10'd514) begin
      errors++;
      $display("FAIL addr_hold: addr=%0d, required 514", addr);
    end
    checks++;
    if (bus !== 32'hzzzz_zzzz && bus !== 32'd0) begin
      errors++;
      $display("FAIL done_bus: bus=0x%08h, required released", bus);
    end
  endtask

  task automatic test_out_of_range();
    int cyc, a0, g0;
    a0 = ack_cnt; g0 = gr_cnt;
    start_job(8'd2, 8'd0, CFG_S1);    // row 2 >= gamma 2
    checks++;
    if (ack !== 1'b1 || rr !== 1'b0) begin
      errors++;
      $display("FAIL oor_ack: ack=%b rr=%b, required ack=1 rr=0", ack, rr);
    end
    wait_done(1'b0, 0, 0, cyc);
    checks++;
    if (cyc != 1) begin
      errors++;
      $display("FAIL oor_latency: cycles=%0d, required 1", cyc);
    end
    checks++;
    if (gr_cnt - g0 != 0) begin
      errors++;
      $display("FAIL oor_request: cycles=%0d, required 0", gr_cnt - g0);
    end
    checks++;
    if (ack_cnt - a0 != 1) begin
      errors++;
      $display("FAIL oor_ack_count: acks=%0d, required 1", ack_cnt - a0);
    end
  endtask

  task automatic test_mu_zero();
    int cyc, g0;
    push_exp(10'd513, 32'd0);
    g0 = gr_cnt;
    start_job(8'd0, 8'd1, 32'h0000_0202);
    wait_done(1'b0, 0, 0, cyc);
    checks++;
    if (cyc != 3) begin
      errors++;
      $display("FAIL mu0_latency: cycles=%0d, required 3", cyc);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL mu0_write_missing: pending=%0d, required 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (gr_cnt - g0 != 2) begin
      errors++;
      $display("FAIL mu0_req_cycles: cycles=%0d, required 2", gr_cnt - g0);
    end
  endtask

  task automatic test_grant_drop();
    int cyc;
    load_s1();
    push_exp(10'd514, 32'd43);
    start_job(8'd1, 8'd0, CFG_S1);
    // Grant withdrawn for 3 edges after the first RD_B cycle: +3, +1 restart
    wait_done(1'b0, 5, 3, cyc);
    checks++;
    if (cyc != 17) begin
      errors++;
      $display("FAIL drop_latency: cycles=%0d, required 17", cyc);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drop_write_missing: pending=%0d, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_job();
    int cyc;
    load_s1();
    start_job(8'd1, 8'd0, CFG_S1);
    repeat (6) @(posedge clk);        // now in MAC
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ack, greq, we, rr} !== 4'b0000 || addr !== 10'd0) begin
      errors++;
      $display("FAIL midreset_outputs: ack/greq/we/rr=%b addr=%0d, required 0000 addr=0",
               {ack, greq, we, rr}, addr);
    end
    checks++;
    if (bus !== 32'hzzzz_zzzz && bus !== 32'd0) begin
      errors++;
      $display("FAIL midreset_bus: bus=0x%08h, required released", bus);
    end
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(10'd514, 32'd43);
    start_job(8'd1, 8'd0, CFG_S1);
    checks++;
    if (ack !== 1'b1) begin
      errors++;
      $display("FAIL postreset_ack: ack=%b, required 1", ack);
    end
    wait_done(1'b0, 0, 0, cyc);
    checks++;
    if (cyc != 13 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL postreset_job: cycles=%0d pending=%0d, required 13 and 0", cyc, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_wrap_and_stray_valid();
    int cyc, a0;
    mem[2]   = 32'h7FFF_FFFF;
    mem[256] = 32'd2;
    push_exp(10'd512, 32'hFFFF_FFFE);
    a0 = ack_cnt;
    start_job(8'd0, 8'd0, 32'h0001_0101);
    wait_done(1'b1, 0, 0, cyc);
    checks++;
    if (cyc != 8) begin
      errors++;
      $display("FAIL wrap_latency: cycles=%0d, required 8", cyc);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_write_missing: pending=%0d, required 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (ack_cnt - a0 != 1) begin
      errors++;
      $display("FAIL stray_valid_ack: acks=%0d, required 1", ack_cnt - a0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rr !== 1'b1) begin
      errors++;
      $display("FAIL wrap_done: rr=%b, required 1", rr);
    end
  endtask

  initial begin
    test_reset();
    test_basic_job();
    test_out_of_range();
    test_mu_zero();
    test_grant_drop();
    test_reset_mid_job();
    test_wrap_and_stray_valid();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
